// File: rtl/riscv_regfile_sb.sv
// Integer register file: N combinational read ports, one write port, optional write-through
// bypass and hardwired x0, plus a per-register saturating pending-write scoreboard for RAW checks.
module riscv_regfile_sb #(
   parameter int ADDR_WIDTH    = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_RPORTS    = 2,
   parameter int WRITE_THROUGH = 1,
   parameter int ZERO_REG      = 1,
   parameter int PEND_WIDTH    = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
   output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
   output logic [NUM_RPORTS-1:0]            rbusy_o,
   input  logic                             we_i,
   input  logic [ADDR_WIDTH-1:0]            waddr_i,
   input  logic [DATA_WIDTH-1:0]            wdata_i,
   input  logic                             issue_i,
   input  logic [ADDR_WIDTH-1:0]            issue_addr_i,
   input  logic                             flush_i,
   output logic [2**ADDR_WIDTH-1:0]         busy_vec_o,
   output logic                             overflow_o
);

   localparam int NREGS = 2 ** ADDR_WIDTH;
   localparam logic [PEND_WIDTH-1:0] CNT_ZERO = {PEND_WIDTH{1'b0}};
   localparam logic [PEND_WIDTH-1:0] CNT_ONE  = PEND_WIDTH'(1);
   localparam logic [PEND_WIDTH-1:0] CNT_MAX  = {PEND_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

   logic [DATA_WIDTH-1:0] regs_q [NREGS];
   logic [DATA_WIDTH-1:0] regs_d [NREGS];
   logic [PEND_WIDTH-1:0] cnt_q  [NREGS];
   logic [PEND_WIDTH-1:0] cnt_d  [NREGS];
   logic [NREGS-1:0]      busy_vec_q;
   logic [NREGS-1:0]      busy_vec_d;
   logic                  overflow_q;
   logic                  overflow_d;
   logic                  wr_en_s;

   // Writes to a hardwired x0 are dropped here so neither the array nor the bypass sees them.
   assign wr_en_s = we_i && !((ZERO_REG != 0) && (waddr_i == ADDR_ZERO));

   // Next register contents from the WB write port.
   always_comb begin
      regs_d = regs_q;
      if (wr_en_s) begin
         regs_d[waddr_i] = wdata_i;
      end else begin
         regs_d[waddr_i] = regs_q[waddr_i];
      end
   end

   // Scoreboard next state: flush wins, matched issue+write cancels, saturation flags overflow.
   always_comb begin
      logic inc_s;
      logic dec_s;
      inc_s      = 1'b0;
      dec_s      = 1'b0;
      overflow_d = overflow_q;
      busy_vec_d = {NREGS{1'b0}};
      for (int r = 0; r < NREGS; r++) begin
         inc_s    = issue_i && (issue_addr_i == ADDR_WIDTH'(r));
         dec_s    = we_i && (waddr_i == ADDR_WIDTH'(r)) && (cnt_q[r] != CNT_ZERO);
         cnt_d[r] = cnt_q[r];
         if (flush_i) begin
            cnt_d[r] = CNT_ZERO;
         end else if ((ZERO_REG != 0) && (r == 0)) begin
            cnt_d[r] = CNT_ZERO;
         end else if (inc_s && !dec_s) begin
            if (cnt_q[r] == CNT_MAX) begin
               overflow_d = 1'b1;
            end else begin
               cnt_d[r] = cnt_q[r] + CNT_ONE;
            end
         end else if (dec_s && !inc_s) begin
            cnt_d[r] = cnt_q[r] - CNT_ONE;
         end else begin
            cnt_d[r] = cnt_q[r];
         end
         busy_vec_d[r] = (cnt_d[r] != CNT_ZERO);
      end
   end

   // Read ports; a write retiring the last pending producer clears busy when its data is bypassed.
   always_comb begin
      logic [ADDR_WIDTH-1:0] ra_s;
      logic                  hit_s;
      ra_s    = ADDR_ZERO;
      hit_s   = 1'b0;
      rdata_o = {(NUM_RPORTS*DATA_WIDTH){1'b0}};
      rbusy_o = {NUM_RPORTS{1'b0}};
      for (int k = 0; k < NUM_RPORTS; k++) begin
         ra_s  = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
         hit_s = (WRITE_THROUGH != 0) && we_i && (waddr_i == ra_s);
         if ((ZERO_REG != 0) && (ra_s == ADDR_ZERO)) begin
            rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
         end else if (hit_s) begin
            rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = wdata_i;
         end else begin
            rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra_s];
         end
         if (hit_s && (cnt_q[ra_s] == CNT_ONE) && !(issue_i && (issue_addr_i == ra_s))) begin
            rbusy_o[k] = 1'b0;
         end else begin
            rbusy_o[k] = (cnt_q[ra_s] != CNT_ZERO);
         end
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= {DATA_WIDTH{1'b0}};
            cnt_q[i]  <= CNT_ZERO;
         end
         busy_vec_q <= {NREGS{1'b0}};
         overflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
            cnt_q[i]  <= cnt_d[i];
         end
         busy_vec_q <= busy_vec_d;
         overflow_q <= overflow_d;
      end
   end

   assign busy_vec_o = busy_vec_q;
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Bench for riscv_regfile_sb: directed scenarios plus random traffic against a behavioural model,
// driving a write-through instance and a non-write-through instance from the same inputs.
module tb_riscv_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [4:0]  ra0, ra1;
   logic        we, issue, flush;
   logic [4:0]  waddr, iaddr;
   logic [31:0] wdata;
   logic [9:0]  raddr_s;
   logic [63:0] rdata_wt, rdata_nwt;
   logic [1:0]  rbusy_wt, rbusy_nwt;
   logic [31:0] busy_wt, busy_nwt;
   logic        ovf_wt, ovf_nwt;

   assign raddr_s = {ra1, ra0};

   always #5 clk = ~clk;

   riscv_regfile_sb #(.WRITE_THROUGH(1)) dut_wt (
      .clk_i(clk), .rst_ni(rst_ni), .raddr_i(raddr_s), .rdata_o(rdata_wt), .rbusy_o(rbusy_wt),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .issue_i(issue), .issue_addr_i(iaddr),
      .flush_i(flush), .busy_vec_o(busy_wt), .overflow_o(ovf_wt));

   riscv_regfile_sb #(.WRITE_THROUGH(0)) dut_nwt (
      .clk_i(clk), .rst_ni(rst_ni), .raddr_i(raddr_s), .rdata_o(rdata_nwt), .rbusy_o(rbusy_nwt),
      .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .issue_i(issue), .issue_addr_i(iaddr),
      .flush_i(flush), .busy_vec_o(busy_nwt), .overflow_o(ovf_nwt));

   // Reference model: register contents, pending counts (saturating at 3), sticky overflow.
   logic [31:0] mem [32];
   int          cnt [32];
   bit          ovf;
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_rdata(input logic [4:0] a, input bit wt);
      if (a == 5'd0) return 32'd0;
      if (wt && we && waddr == a) return wdata;
      return mem[a];
   endfunction

   function automatic logic exp_rbusy(input logic [4:0] a, input bit wt);
      if (wt && we && waddr == a && cnt[a] == 1 && !(issue && iaddr == a)) return 1'b0;
      return cnt[a] != 0;
   endfunction

   function automatic logic [31:0] exp_busy();
      logic [31:0] v;
      for (int r = 0; r < 32; r++) v[r] = (cnt[r] != 0);
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         mem[r] = 32'd0;
         cnt[r] = 0;
      end
      ovf = 1'b0;
   endtask

   task automatic model_update();
      if (we && waddr != 5'd0) mem[waddr] = wdata;
      if (flush) begin
         for (int r = 0; r < 32; r++) cnt[r] = 0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            bit inc, dec;
            inc = issue && iaddr == r;
            dec = we && waddr == r && cnt[r] != 0;
            if (inc && !dec) begin
               if (cnt[r] == 3) ovf = 1'b1;
               else cnt[r]++;
            end else if (dec && !inc) begin
               cnt[r]--;
            end
         end
      end
   endtask

   task automatic check_model();
      for (int k = 0; k < 2; k++) begin
         logic [4:0] a;
         a = (k == 0) ? ra0 : ra1;
         check_val($sformatf("rdata_wt[%0d]", k), rdata_wt[k*32 +: 32], exp_rdata(a, 1'b1));
         check_val($sformatf("rdata_nwt[%0d]", k), rdata_nwt[k*32 +: 32], exp_rdata(a, 1'b0));
         check_val($sformatf("rbusy_wt[%0d]", k), rbusy_wt[k], exp_rbusy(a, 1'b1));
         check_val($sformatf("rbusy_nwt[%0d]", k), rbusy_nwt[k], exp_rbusy(a, 1'b0));
      end
      check_val("busy_vec_wt", busy_wt, exp_busy());
      check_val("busy_vec_nwt", busy_nwt, exp_busy());
      check_val("overflow_wt", ovf_wt, ovf);
      check_val("overflow_nwt", ovf_nwt, ovf);
   endtask

   // One clock: inputs were set after a falling edge; check, clock, advance the model.
   task automatic step();
      #1;
      check_model();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      we = 1'b0; waddr = 5'd0; wdata = 32'd0;
      issue = 1'b0; iaddr = 5'd0; flush = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0;
      idle();
      ra0 = 5'd5; ra1 = 5'd0;
      model_reset();
      #2;
      check_val("reset_rdata", rdata_wt, 64'd0);
      check_val("reset_rbusy", rbusy_wt, 64'd0);
      check_val("reset_busy_vec", busy_wt, 64'd0);
      check_val("reset_overflow", ovf_wt, 64'd0);
      @(negedge clk);
      rst_ni = 1'b1;

      // Basic write and x0 behaviour.
      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      step();
      idle(); ra0 = 5'd5; ra1 = 5'd0;
      #1;
      check_val("read_x5", rdata_wt[31:0], 64'hDEADBEEF);
      check_val("read_x0", rdata_wt[63:32], 64'd0);
      we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
      step();
      idle();
      #1;
      check_val("x0_after_write", rdata_wt[63:32], 64'd0);

      // Write-through versus registered-only visibility.
      we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; ra1 = 5'd7;
      #1;
      check_val("wt_bypass", rdata_wt[63:32], 64'hA5A5A5A5);
      check_val("nwt_old", rdata_nwt[63:32], 64'd0);
      step();
      idle();
      #1;
      check_val("nwt_next", rdata_nwt[63:32], 64'hA5A5A5A5);

      // Issue then retire x3 with a bypassed read.
      issue = 1'b1; iaddr = 5'd3;
      step();
      idle(); ra0 = 5'd3;
      #1;
      check_val("busy_vec_x3", busy_wt[3], 64'd1);
      check_val("rbusy_x3", rbusy_wt[0], 64'd1);
      we = 1'b1; waddr = 5'd3; wdata = 32'h77;
      #1;
      check_val("rbusy_x3_bypass", rbusy_wt[0], 64'd0);
      check_val("rdata_x3_bypass", rdata_wt[31:0], 64'h77);
      check_val("rbusy_x3_nwt", rbusy_nwt[0], 64'd1);
      step();
      idle();
      #1;
      check_val("busy_vec_x3_clear", busy_wt[3], 64'd0);

      // Saturation and overflow on x9.
      for (int i = 0; i < 4; i++) begin
         idle(); issue = 1'b1; iaddr = 5'd9;
         #1;
         check_val("ovf_before_sat", ovf_wt, 64'd0);
         step();
      end
      idle();
      #1;
      check_val("ovf_after_sat", ovf_wt, 64'd1);
      for (int i = 0; i < 3; i++) begin
         idle(); we = 1'b1; waddr = 5'd9; wdata = 32'(i);
         step();
         idle();
         #1;
         check_val("busy_x9_drain", busy_wt[9], (i < 2) ? 64'd1 : 64'd0);
      end
      check_val("ovf_sticky", ovf_wt, 64'd1);

      // Simultaneous issue and write cancel; untracked write leaves count at 0.
      issue = 1'b1; iaddr = 5'd4;
      step();
      idle(); issue = 1'b1; iaddr = 5'd4; we = 1'b1; waddr = 5'd4; wdata = 32'h44; ra0 = 5'd4;
      #1;
      check_val("rbusy_x4_same", rbusy_wt[0], 64'd1);
      step();
      idle();
      #1;
      check_val("busy_x4_kept", busy_wt[4], 64'd1);
      we = 1'b1; waddr = 5'd6; wdata = 32'h66;
      step();
      idle();
      #1;
      check_val("busy_x6_zero", busy_wt[6], 64'd0);
      we = 1'b1; waddr = 5'd4; wdata = 32'h45;
      step();

      // Flush with a concurrent data write.
      for (int i = 0; i < 3; i++) begin
         idle(); issue = 1'b1;
         iaddr = (i == 0) ? 5'd2 : ((i == 1) ? 5'd10 : 5'd31);
         step();
      end
      idle(); flush = 1'b1; we = 1'b1; waddr = 5'd2; wdata = 32'h55;
      step();
      idle(); ra0 = 5'd2;
      #1;
      check_val("flush_busy_vec", busy_wt, 64'd0);
      check_val("flush_x2_data", rdata_wt[31:0], 64'h55);
      check_val("flush_keeps_ovf", ovf_wt, 64'd1);

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         ra0   = 5'($urandom_range(0, 31));
         ra1   = ($urandom % 4 == 0) ? ra0 : 5'($urandom_range(0, 15));
         we    = 1'($urandom % 2);
         waddr = 5'($urandom_range(0, 15));
         wdata = $urandom;
         issue = ($urandom % 3 == 0);
         iaddr = 5'($urandom_range(0, 15));
         flush = ($urandom % 40 == 0);
         step();
      end

      // Asynchronous reset in the middle of activity.
      idle(); issue = 1'b1; iaddr = 5'd5; ra0 = 5'd5; ra1 = 5'd7;
      #1;
      rst_ni = 1'b0;
      #1;
      check_val("async_rst_rdata", rdata_wt, 64'd0);
      check_val("async_rst_rbusy", rbusy_wt, 64'd0);
      check_val("async_rst_busy", busy_wt, 64'd0);
      check_val("async_rst_ovf", ovf_wt, 64'd0);
      model_reset();
      @(negedge clk);
      rst_ni = 1'b1;
      for (int n = 0; n < 200; n++) begin
         ra0   = 5'($urandom_range(0, 7));
         ra1   = 5'($urandom_range(0, 7));
         we    = 1'($urandom % 2);
         waddr = 5'($urandom_range(0, 7));
         wdata = $urandom;
         issue = 1'($urandom % 2);
         iaddr = 5'($urandom_range(0, 7));
         flush = ($urandom % 50 == 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/riscv_regfile_sb.md
Name: riscv_regfile_sb

Overview:
- Parametrised integer register file with N combinational read ports and one write port.
- Optional write-through bypass and hardwired-zero register.
- Per-register pending-write scoreboard (saturating counters) so the ID stage can detect RAW hazards on multi-cycle producers (loads, future MUL/DIV) without a separate forwarding lookup.
- Sits between the ID stage (read, issue) and the WB stage (write).

Parameters:
- ADDR_WIDTH, 5, register index width; NREGS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.
- NUM_RPORTS, 2, number of read ports (>=1).
- WRITE_THROUGH, 1, 1 = same-cycle write data visible on reads to the same address.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never pending.
- PEND_WIDTH, 2, width of each per-register pending counter (>=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- raddr_i  in  NUM_RPORTS*ADDR_WIDTH  read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rdata_o  out  NUM_RPORTS*DATA_WIDTH  read data, same packing.
- rbusy_o  out  NUM_RPORTS  read register k has an outstanding write.
- we_i  in  1  write enable (WB).
- waddr_i  in  ADDR_WIDTH  write address.
- wdata_i  in  DATA_WIDTH  write data.
- issue_i  in  1  a producer targeting issue_addr_i is issued.
- issue_addr_i  in  ADDR_WIDTH  destination register of the issued producer.
- flush_i  in  1  clear all pending counters (pipeline flush).
- busy_vec_o  out  2**ADDR_WIDTH  registered per-register pending flag (count != 0).
- overflow_o  out  1  sticky: issue attempted on a saturated counter.

Behaviour:
- Reset (async, rst_ni=0):
  - All registers = 0.
  - All pending counters = 0.
  - overflow_o = 0.
  - busy_vec_o = 0.
  - rdata_o follows the reset register contents (0); rbusy_o = 0.
- Write:
  - On the rising edge with we_i=1, reg[waddr_i] <= wdata_i.
  - If ZERO_REG=1 and waddr_i=0, the write is dropped.
- Read (combinational, zero latency): rdata_o[k] = reg[raddr_k], except:
  - ZERO_REG=1 and raddr_k=0 -> 0.
  - WRITE_THROUGH=1, we_i=1, waddr_i=raddr_k (and not the dropped x0 case) -> wdata_i.
  - WRITE_THROUGH=0 -> old register value until the next cycle.
- Scoreboard, per register r, counter cnt[r] (PEND_WIDTH bits). Next-state rules, highest priority first:
  1. flush_i=1 -> cnt[r] <= 0 for all r. Issue and write in the same cycle are ignored for scoreboard purposes; the register data write still commits.
  2. inc = issue_i && issue_addr_i==r; dec = we_i && waddr_i==r && cnt[r]!=0.
  3. inc && dec -> unchanged.
  4. inc only -> cnt+1. If cnt is at all-ones, cnt holds and overflow_o <= 1.
  5. dec only -> cnt-1.
  6. Write with cnt=0 -> no change (untracked producer, e.g. single-cycle ALU op).
  7. ZERO_REG=1: r=0 is never incremented or decremented; it stays 0.
- busy_vec_o[r] = (cnt[r] != 0), taken from the flop state.
- rbusy_o[k]:
  - Base value is cnt[raddr_k] != 0.
  - With WRITE_THROUGH=1: if we_i && waddr_i==raddr_k && cnt==1 && !(issue_i && issue_addr_i==raddr_k), then rbusy_o[k]=0. The bypassed data is the final value.
  - With WRITE_THROUGH=0: no bypass adjustment.
  - rbusy_o does not reflect the same-cycle issue_i; the new pending state is visible from the next cycle.
- overflow_o: sticky, cleared only by reset; flush_i does not clear it.
- Multiple read ports with the same address return identical data and busy.
- Reset asserted mid-operation clears all state immediately, regardless of we_i, issue_i or flush_i.

Test Plan:
- Reset, then write x5=0xDEADBEEF; next cycle read ports 0/1 at x5/x0 -> 0xDEADBEEF / 0x0. A write of 0x1234 to x0 leaves x0 reading 0.
- WRITE_THROUGH=1: write x7=0xA5A5A5A5 while port 1 reads x7 in the same cycle -> rdata=0xA5A5A5A5. With WRITE_THROUGH=0, the same stimulus returns the old value 0, then 0xA5A5A5A5 the next cycle.
- issue x3 -> busy_vec_o[3]=1 and rbusy on x3 = 1 from the next cycle. WB write to x3 in the same cycle that port 0 reads x3 -> rbusy_o[0]=0 that cycle with bypassed data; busy_vec_o[3]=0 the cycle after.
- PEND_WIDTH=2: four issues to x9 with no writes -> cnt saturates at 3, overflow_o=1 after the 4th. Three writes to x9 -> busy clears only after the 3rd. overflow_o remains 1.
- Issue to x4 and write to x4 in the same cycle with cnt=1 -> cnt stays 1, rbusy for x4 = 1. A write to x6 with cnt=0 -> cnt stays 0.
- Pend x2, x10, x31, then assert flush_i together with a write x2=0x55 -> busy_vec_o=0 next cycle, x2 reads 0x55. Asserting rst_ni=0 mid-sequence zeroes all registers and outputs asynchronously.
